// File: rtl/stream_parser.sv
// stream_parser: splits a word stream into headered packets, emits payloads and
// flags per-stream sequence gaps; malformed packets are dropped with formatErr.
module stream_parser #(
  parameter int NUM_STREAMS = 32,
  parameter int PAYLOAD_WORDS = 10,
  localparam int SID_W = $clog2(NUM_STREAMS)
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic [31:0]                dataIn,
  input  logic                       dataIn_val,
  input  logic                       dataIN_last,
  output logic                       dataIn_ready,
  output logic [32*PAYLOAD_WORDS-1:0] dataOut,
  output logic                       dataOut_val,
  input  logic                       dataOut_ready,
  output logic [SID_W-1:0]           dataOut_stream,
  output logic [15:0]                dataOut_bytes,
  output logic [31:0]                dataOut_seq,
  output logic                       packetLost,
  output logic [31:0]                gapCount,
  output logic                       formatErr
);
  localparam int MAXB = 4*PAYLOAD_WORDS;
  localparam int IW = $clog2(PAYLOAD_WORDS+1);
  typedef enum logic [2:0] {HDR, SEQW, DATA, DROP, COMMIT} state_t;
  state_t state_q, state_d;
  logic [15:0] p_q, p_d;
  logic [SID_W-1:0] sid_q, sid_d;
  logic [31:0] seq_q, seq_d;
  logic [IW-1:0] idx_q, idx_d, w_q, w_d;
  logic [31:0] buf_q [PAYLOAD_WORDS];
  logic [31:0] exp_q [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] seen_q;
  logic [32*PAYLOAD_WORDS-1:0] dout_q, flat;
  logic val_q, lost_q, ferr_q, ferr_d;
  logic [SID_W-1:0] stream_q;
  logic [15:0] bytes_q;
  logic [31:0] oseq_q, gap_q;
  logic xfer, commit, clr, wr_en, fin, bad, lost;
  logic [31:0] mask, wdata, exp_nxt, gap;
  assign dataIn_ready = state_q != COMMIT;
  assign xfer = dataIn_val && dataIn_ready;
  assign commit = state_q == COMMIT && (!val_q || dataOut_ready);
  assign fin = idx_q == w_q - IW'(1);
  // final word keeps only the bytes that belong to the payload, MSB first
  assign mask = p_q[1:0] == 2'd0 ? '1 : ~(32'hFFFF_FFFF >> {p_q[1:0], 3'b000});
  assign wdata = dataIn & (fin ? mask : '1);
  assign bad = dataIn[31:16] < 16'd8 || dataIn[31:16] - 16'd8 > 16'(MAXB) ||
               dataIn[15:0] >= 16'(NUM_STREAMS) || dataIN_last;
  assign exp_nxt = exp_q[sid_q] + 32'd1;
  assign lost = seen_q[sid_q] && seq_q != exp_nxt;
  assign gap = lost ? seq_q - exp_nxt : '0;
  assign dataOut = dout_q;
  assign dataOut_val = val_q;
  assign dataOut_stream = stream_q;
  assign dataOut_bytes = bytes_q;
  assign dataOut_seq = oseq_q;
  assign packetLost = lost_q;
  assign gapCount = gap_q;
  assign formatErr = ferr_q;
  always_comb begin
    flat = '0;
    for (int i = 0; i < PAYLOAD_WORDS; i++) flat[32*(PAYLOAD_WORDS-1-i) +: 32] = buf_q[i];
  end
  always_comb begin
    state_d = state_q;
    p_d = p_q;
    sid_d = sid_q;
    seq_d = seq_q;
    idx_d = idx_q;
    w_d = w_q;
    ferr_d = 1'b0;
    wr_en = 1'b0;
    clr = commit;
    case (state_q)
      HDR: if (xfer) begin
        clr = 1'b1;
        if (bad) begin
          state_d = dataIN_last ? HDR : DROP;
          ferr_d = dataIN_last;
        end else begin
          state_d = SEQW;
          p_d = dataIn[31:16] - 16'd8;
          sid_d = dataIn[SID_W-1:0];
          w_d = IW'((dataIn[31:16] - 16'd5) >> 2);
        end
      end
      SEQW: if (xfer) begin
        seq_d = dataIn;
        idx_d = '0;
        if (p_q == '0) state_d = dataIN_last ? COMMIT : DROP;
        else begin
          state_d = dataIN_last ? HDR : DATA;
          ferr_d = dataIN_last;
        end
      end
      DATA: if (xfer) begin
        wr_en = 1'b1;
        idx_d = idx_q + IW'(1);
        if (fin) state_d = dataIN_last ? COMMIT : DROP;
        else if (dataIN_last) begin
          state_d = HDR;
          ferr_d = 1'b1;
        end
      end
      DROP: if (xfer && dataIN_last) begin
        state_d = HDR;
        ferr_d = 1'b1;
      end
      COMMIT: if (commit) state_d = HDR;
      default: state_d = HDR;
    endcase
  end
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= HDR;
      p_q <= '0;
      sid_q <= '0;
      seq_q <= '0;
      idx_q <= '0;
      w_q <= '0;
      buf_q <= '{default: '0};
      exp_q <= '{default: '0};
      seen_q <= '0;
      dout_q <= '0;
      val_q <= 1'b0;
      stream_q <= '0;
      bytes_q <= '0;
      oseq_q <= '0;
      lost_q <= 1'b0;
      gap_q <= '0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      sid_q <= sid_d;
      seq_q <= seq_d;
      idx_q <= idx_d;
      w_q <= w_d;
      ferr_q <= ferr_d;
      if (clr) buf_q <= '{default: '0};
      else if (wr_en) buf_q[idx_q] <= wdata;
      if (commit) begin
        dout_q <= flat;
        val_q <= 1'b1;
        stream_q <= sid_q;
        bytes_q <= p_q;
        oseq_q <= seq_q;
        lost_q <= lost;
        gap_q <= gap;
        exp_q[sid_q] <= seq_q;
        seen_q[sid_q] <= 1'b1;
      end else if (val_q && dataOut_ready) begin
        val_q <= 1'b0;
        lost_q <= 1'b0;
        gap_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_stream_parser.sv
// tb_stream_parser: scoreboard bench with a packet-level reference model of the parser.
module tb_stream_parser;
  localparam int NS = 32;
  localparam int PW = 10;
  localparam int MAXB = 4*PW;
  localparam int DW = 32*PW;
  typedef struct {
    logic [DW-1:0] data;
    logic [4:0]    sid;
    logic [15:0]   bytes;
    logic [31:0]   seq;
    logic          lost;
    logic [31:0]   gap;
  } exp_t;
  logic clk = 1'b0, reset_b = 1'b0;
  logic [31:0] dataIn = '0;
  logic dataIn_val = 1'b0, dataIN_last = 1'b0, dataOut_ready = 1'b0;
  logic dataIn_ready, dataOut_val, packetLost, formatErr;
  logic [DW-1:0] dataOut;
  logic [4:0] dataOut_stream;
  logic [15:0] dataOut_bytes;
  logic [31:0] dataOut_seq, gapCount;
  int checks = 0, errors = 0, ferr_seen = 0, ferr_exp = 0;
  exp_t sbq[$];
  exp_t e, prev;
  logic hold = 1'b0;
  logic rand_rdy = 1'b0;
  logic [31:0] m_exp [NS];
  logic m_seen [NS];
  logic [31:0] pw[$];
  logic [31:0] rseq [40];

  stream_parser #(.NUM_STREAMS(NS), .PAYLOAD_WORDS(PW)) dut (
    .clk(clk), .reset_b(reset_b), .dataIn(dataIn), .dataIn_val(dataIn_val),
    .dataIN_last(dataIN_last), .dataIn_ready(dataIn_ready), .dataOut(dataOut),
    .dataOut_val(dataOut_val), .dataOut_ready(dataOut_ready), .dataOut_stream(dataOut_stream),
    .dataOut_bytes(dataOut_bytes), .dataOut_seq(dataOut_seq), .packetLost(packetLost),
    .gapCount(gapCount), .formatErr(formatErr));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_b) begin
      if (formatErr) ferr_seen++;
      if (hold) begin
        chk("hold_data", dataOut, prev.data);
        chk("hold_meta", {dataOut_stream, dataOut_bytes, dataOut_seq, packetLost, gapCount},
            {prev.sid, prev.bytes, prev.seq, prev.lost, prev.gap});
      end
      if (dataOut_val && dataOut_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got stream %0d seq %0h expected none", dataOut_stream, dataOut_seq);
        end else begin
          e = sbq.pop_front();
          chk("out_data", dataOut, e.data);
          chk("out_stream", dataOut_stream, e.sid);
          chk("out_bytes", dataOut_bytes, e.bytes);
          chk("out_seq", dataOut_seq, e.seq);
          chk("out_lost", packetLost, e.lost);
          chk("out_gap", gapCount, e.gap);
        end
      end
      hold = dataOut_val && !dataOut_ready;
      prev.data = dataOut;
      prev.sid = dataOut_stream;
      prev.bytes = dataOut_bytes;
      prev.seq = dataOut_seq;
      prev.lost = packetLost;
      prev.gap = gapCount;
    end else hold = 1'b0;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) dataOut_ready = 1'($urandom_range(0, 1));
  end

  // Packet-level rule: a packet is good when its header is legal and it carries
  // exactly 2+ceil(P/4) words, with last only on the final one.
  task automatic model();
    int len, sid, p, n;
    exp_t x;
    len = int'(pw[0][31:16]);
    sid = int'(pw[0][15:0]);
    p = len - 8;
    n = pw.size();
    if (n < 2 || len < 8 || p > MAXB || sid >= NS || n != 2 + (p + 3) / 4) ferr_exp++;
    else begin
      x.data = '0;
      for (int b = 0; b < p; b++) x.data[DW-1-8*b -: 8] = pw[2 + b/4][31-8*(b%4) -: 8];
      x.sid = 5'(sid);
      x.bytes = 16'(p);
      x.seq = pw[1];
      x.lost = m_seen[sid] && pw[1] != m_exp[sid] + 32'd1;
      x.gap = x.lost ? pw[1] - (m_exp[sid] + 32'd1) : 32'd0;
      m_exp[sid] = pw[1];
      m_seen[sid] = 1'b1;
      sbq.push_back(x);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    dataIn = w;
    dataIn_val = 1'b1;
    dataIN_last = last;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = dataIn_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no ready expected ready within 200 cycles");
    end
    dataIn_val = 1'b0;
    dataIN_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int gaps);
    model();
    for (int i = 0; i < pw.size(); i++) begin
      send_word(pw[i], i == pw.size() - 1);
      if (gaps != 0 && $urandom_range(0, 2) == 0) idle(1);
    end
  endtask

  initial begin
    int n, sid, len, nw, dj;
    for (int i = 0; i < NS; i++) begin
      m_exp[i] = '0;
      m_seen[i] = 1'b0;
    end
    for (int i = 0; i < 40; i++) rseq[i] = $urandom;
    rseq[7] = 32'hFFFF_FFFD;
    idle(3);
    chk("rst_val", dataOut_val, 1'b0);
    chk("rst_data", dataOut, '0);
    chk("rst_lost", packetLost, 1'b0);
    chk("rst_gap", gapCount, '0);
    chk("rst_ferr", formatErr, 1'b0);
    reset_b = 1'b1;
    dataOut_ready = 1'b1;
    idle(2);
    pw = '{32'h000E_0003, 32'd5, 32'hAABBCCDD, 32'h1122_3344};
    model();
    for (int i = 0; i < 4; i++) send_word(pw[i], i == 3);
    chk("lat_edge_k", dataOut_val, 1'b0);
    idle(1);
    chk("lat_edge_k1", dataOut_val, 1'b1);
    chk("r20_msw", dataOut[DW-1 -: 64], 64'hAABBCCDD_11220000);
    chk("r20_rest", dataOut[DW-65:0], '0);
    chk("r20_bytes", dataOut_bytes, 16'd6);
    chk("r20_lost", packetLost, 1'b0);
    idle(2);
    pw = '{32'h000C_0003, 32'd8, 32'h1234_5678};
    send_pkt(0);
    idle(1);
    chk("r21_lost", packetLost, 1'b1);
    chk("r21_gap", gapCount, 32'd2);
    idle(2);
    pw = '{32'h000C_0003, 32'd9, 32'h8765_4321};
    send_pkt(0);
    idle(1);
    chk("r21_inorder", packetLost, 1'b0);
    idle(2);
    pw = '{32'h000C_0028, 32'd7, 32'hDEAD_BEEF};
    send_pkt(0);
    idle(4);
    chk("r22_noout", dataOut_val, 1'b0);
    chk("r22_ferr", ferr_seen, ferr_exp);
    pw = '{32'h000C_0008, 32'd100, 32'h0BAD_F00D};
    send_pkt(0);
    idle(1);
    chk("r22_table", packetLost, 1'b0);
    idle(2);
    dataOut_ready = 1'b0;
    pw = '{32'h000C_0001, 32'd1, 32'hCAFE_0001};
    send_pkt(0);
    pw = '{32'h0010_0002, 32'd1, 32'hCAFE_0002, 32'hCAFE_0003};
    send_pkt(0);
    idle(2);
    @(negedge clk);
    chk("r23_inready", dataIn_ready, 1'b0);
    chk("r23_first", dataOut_stream, 5'd1);
    @(posedge clk);
    #1;
    dataOut_ready = 1'b1;
    @(negedge clk);
    chk("r23_deliver1", dataOut_stream, 5'd1);
    @(negedge clk);
    chk("r23_deliver2", {dataOut_val, dataOut_stream}, {1'b1, 5'd2});
    idle(3);
    dataOut_ready = 1'b0;
    pw = '{32'h000C_0005, 32'd50, 32'h5555_5555};
    send_pkt(0);
    send_word(32'h0014_0005, 1'b0);
    send_word(32'd51, 1'b0);
    send_word(32'h6666_6666, 1'b0);
    #3;
    reset_b = 1'b0;
    #1;
    chk("r24_val", dataOut_val, 1'b0);
    chk("r24_data", dataOut, '0);
    chk("r24_lost", packetLost, 1'b0);
    sbq.delete();
    for (int i = 0; i < NS; i++) begin
      m_exp[i] = '0;
      m_seen[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    dataOut_ready = 1'b1;
    pw = '{32'h000C_0005, 32'd77, 32'h7777_7777};
    send_pkt(0);
    idle(1);
    chk("r24_seen_clr", {dataOut_val, packetLost}, {1'b1, 1'b0});
    idle(2);
    pw = '{32'h0008_0004, 32'd3};
    send_pkt(0);
    idle(1);
    chk("r25_len8", {dataOut_val, dataOut_bytes}, {1'b1, 16'd0});
    chk("r25_zero", dataOut, '0);
    idle(2);
    pw = '{32'h0010_0006, 32'd1, 32'h1111_1111};
    send_pkt(0);
    idle(4);
    chk("r25_early_noout", dataOut_val, 1'b0);
    chk("r25_ferr", ferr_seen, ferr_exp);
    rand_rdy = 1'b1;
    for (int k = 0; k < 150; k++) begin
      sid = ($urandom_range(0, 9) == 0) ? int'($urandom_range(32, 39)) : int'($urandom_range(0, 31));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(8, 48));
      nw = (len >= 8) ? 2 + (len - 5) / 4 : 2;
      dj = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) - 1 : 0;
      nw = (nw + dj < 1) ? 1 : nw + dj;
      rseq[sid] = rseq[sid] + (($urandom_range(0, 4) == 0) ? 32'($urandom_range(2, 4)) : 32'd1);
      pw.delete();
      pw.push_back({16'(len), 16'(sid)});
      if (nw > 1) pw.push_back(rseq[sid]);
      for (int i = 2; i < nw; i++) pw.push_back($urandom);
      send_pkt(1);
    end
    n = 0;
    while (sbq.size() > 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
    rand_rdy = 1'b0;
    #1;
    dataOut_ready = 1'b1;
    idle(4);
    chk("ferr_count", ferr_seen, ferr_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
